redundancy_dist_scheduler: RTL and testbench
============================================

Name: redundancy_dist_scheduler

Overview:
Sequencing controller that streams redundant weight-pair indices through a pipelined pair-distance stage. It latches the layer shape (OW, FW, S) at start and accepts (idx1, idx2) pairs over a valid/ready stream. It emits only stride-aligned, in-range row distances downstream and counts accepted and dropped pairs. It sits between the redundancy detector's pair queue and the reuse table writer.

Parameters:
WORD_WIDTH, 8, width of indices and shape fields
DIST_WIDTH, 7, width of emitted distance dr
CNT_WIDTH, 16, width of pair/drop counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latch cfg, clear counters, begin run
cfg_ow  in  WORD_WIDTH  output width OW
cfg_fw  in  WORD_WIDTH  filter width FW
cfg_st  in  WORD_WIDTH  stride S
in_valid  in  1  pair valid
in_ready  out  1  pair accepted when in_valid & in_ready
in_idx1  in  WORD_WIDTH  smaller pair index
in_idx2  in  WORD_WIDTH  larger pair index
in_last  in  1  final pair of run
out_valid  out  1  distance valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_dr  out  DIST_WIDTH  row distance
out_idx1  out  WORD_WIDTH  idx1 of the emitted pair
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of run
cfg_err  out  1  one-cycle pulse: start rejected
pair_cnt  out  CNT_WIDTH  pairs accepted this run
drop_cnt  out  CNT_WIDTH  pairs dropped this run

Behaviour:
- Reset (synchronous, active-high, clk domain only) forces state IDLE. All outputs return to 0: in_ready, out_valid, out_dr, out_idx1, busy, done, cfg_err, pair_cnt, drop_cnt. Both pipeline stages are emptied. Reset mid-run discards in-flight pairs and emits no done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start with FW != 0, S != 0 and OW >= FW, latch cfg, clear counters and go to RUN. On start with an illegal cfg, pulse cfg_err and stay in IDLE. Start is ignored outside IDLE.
- RUN: in_ready = s1 empty, or s1 advancing this cycle. Each acceptance increments pair_cnt. Accepting a pair with in_last moves to DRAIN.
- DRAIN: in_ready = 0. Move to DONE when s1 and s2 are both empty.
- DONE: pulse done for one cycle, then go to IDLE. Counters hold their values until the next start.
- Pipeline s1: registers idx1/idx2 on accept.
- Pipeline s2: registers dr and idx1 computed combinationally from s1.
- s2 loads when s2 is empty or out_ready is high. out_valid = s2 valid. Latency from accept to out_valid is 2 cycles. Throughput is 1 pair/cycle with out_ready held high.
- Distance arithmetic:
  - d = idx2 - idx1
  - dv = idx2/FW - idx1/FW (integer quotients)
  - n = (OW - FW)*dv + d, computed at 2*WORD_WIDTH bits
  - dr = n / S
- Drop rule: a pair is dropped when n mod S != 0, when dr >= 2^DIST_WIDTH, or when idx2 < idx1. A dropped pair increments drop_cnt when it leaves s1 and is never loaded into s2.
- out_dr and out_idx1 hold stable while out_valid & !out_ready.
- Counters wrap modulo 2^CNT_WIDTH.
- Simultaneous s2 emit and s1 advance in the same cycle is legal. No bubble may be inserted.

Decomposition:
- Shared package, constants: DEFAULT_WORD_WIDTH=8, DEFAULT_DIST_WIDTH=7.
- Shared package, state encoding enum: sched_state_t {IDLE, RUN, DRAIN, DONE}.
- Shared package, function: cfg_legal(ow, fw, st).
- One sub-module, pair_distance_unit: combinational idx1/idx2/OW/FW/S to dr plus keep flag (the arithmetic and drop rule above), instantiated between s1 and s2.

Test Plan:
1. OW=8, FW=3, S=1; pair (1,4) with last, out_ready=1 -> out_dr=8 two cycles after accept; done pulse follows; pair_cnt=1, drop_cnt=0.
2. OW=8, FW=3, S=2, pair (1,4) -> out_dr=4. Same cfg with S=3 -> pair dropped (8 mod 3=2): no out_valid, drop_cnt=1, done still pulses.
3. OW=40, FW=3, S=1, pair (0,60) -> n=37*20+60=800 >= 128, so dropped: drop_cnt=1.
4. Back-to-back stream of 4 legal pairs; out_ready held low for 3 cycles from the first out_valid -> out_dr stable, in_ready falls once s1 and s2 are full, all 4 emitted in order, none lost or duplicated.
5. start with FW=0 (and separately S=0, and OW=2 with FW=3) -> cfg_err for 1 cycle, busy stays 0, in_ready=0.
6. Reset asserted in RUN with both stages full -> next cycle out_valid=0, busy=0, counters=0, and no done pulse.

Source files
------------

// File: rtl/redundancy_dist_scheduler_pkg.sv
// redundancy_dist_scheduler_pkg: shared widths, scheduler states and layer-shape legality check
package redundancy_dist_scheduler_pkg;

    localparam int DEFAULT_WORD_WIDTH = 8;
    localparam int DEFAULT_DIST_WIDTH = 7;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

    function automatic logic cfg_legal(
        input logic [DEFAULT_WORD_WIDTH-1:0] ow,
        input logic [DEFAULT_WORD_WIDTH-1:0] fw,
        input logic [DEFAULT_WORD_WIDTH-1:0] st
    );
        return (fw != '0) && (st != '0) && (ow >= fw);
    endfunction

endpackage

// File: rtl/redundancy_dist_scheduler_pair_distance_unit.sv
// pair_distance_unit: maps an index pair and layer shape to a row distance and a keep flag
module pair_distance_unit #(
    parameter int WORD_WIDTH = 8,
    parameter int DIST_WIDTH = 7
) (
    input  logic [WORD_WIDTH-1:0] idx1_i,
    input  logic [WORD_WIDTH-1:0] idx2_i,
    input  logic [WORD_WIDTH-1:0] ow_i,
    input  logic [WORD_WIDTH-1:0] fw_i,
    input  logic [WORD_WIDTH-1:0] st_i,
    output logic [DIST_WIDTH-1:0] dr_o,
    output logic                  keep_o
);

    localparam int NW = 2 * WORD_WIDTH;
    localparam logic [NW-1:0] DR_LIM = NW'(1) << DIST_WIDTH;

    logic [WORD_WIDTH-1:0] d_w, dv_w, span_w;
    logic [NW-1:0]         n, dr, rem;

    always_comb begin
        d_w    = idx2_i - idx1_i;
        dv_w   = idx2_i / fw_i - idx1_i / fw_i;
        span_w = ow_i - fw_i;
        n      = {{WORD_WIDTH{1'b0}}, span_w} * {{WORD_WIDTH{1'b0}}, dv_w} + {{WORD_WIDTH{1'b0}}, d_w};
        dr     = n / {{WORD_WIDTH{1'b0}}, st_i};
        rem    = n % {{WORD_WIDTH{1'b0}}, st_i};
        keep_o = (idx2_i >= idx1_i) && (rem == '0) && (dr < DR_LIM);
        dr_o   = dr[DIST_WIDTH-1:0];
    end

endmodule

// File: rtl/redundancy_dist_scheduler.sv
// redundancy_dist_scheduler: streams index pairs through a two-stage distance pipeline, dropping unusable pairs
module redundancy_dist_scheduler
    import redundancy_dist_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int DIST_WIDTH = DEFAULT_DIST_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_ow,
    input  logic [WORD_WIDTH-1:0] cfg_fw,
    input  logic [WORD_WIDTH-1:0] cfg_st,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_idx1,
    input  logic [WORD_WIDTH-1:0] in_idx2,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIST_WIDTH-1:0] out_dr,
    output logic [WORD_WIDTH-1:0] out_idx1,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [CNT_WIDTH-1:0]  pair_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    sched_state_t state_q, state_d;
    logic [WORD_WIDTH-1:0] ow_q, fw_q, st_q;
    logic                  s1_v_q, s2_v_q, cfg_err_q;
    logic [WORD_WIDTH-1:0] s1_idx1_q, s1_idx2_q, s2_idx1_q;
    logic [DIST_WIDTH-1:0] s2_dr_q, pdu_dr;
    logic [CNT_WIDTH-1:0]  pair_cnt_q, drop_cnt_q;
    logic                  pdu_keep, s2_free, s1_adv, accept, legal, start_ok;

    pair_distance_unit #(.WORD_WIDTH(WORD_WIDTH), .DIST_WIDTH(DIST_WIDTH)) u_pdu (
        .idx1_i(s1_idx1_q),
        .idx2_i(s1_idx2_q),
        .ow_i  (ow_q),
        .fw_i  (fw_q),
        .st_i  (st_q),
        .dr_o  (pdu_dr),
        .keep_o(pdu_keep)
    );

    // A dropped pair leaves s1 without needing room in s2
    always_comb begin
        s2_free  = !s2_v_q || out_ready;
        s1_adv   = s1_v_q && (!pdu_keep || s2_free);
        in_ready = (state_q == RUN) && (!s1_v_q || s1_adv);
        accept   = in_valid && in_ready;
        legal    = cfg_legal(cfg_ow, cfg_fw, cfg_st);
        start_ok = (state_q == IDLE) && start && legal;
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = start_ok ? RUN : IDLE;
            RUN:     state_d = (accept && in_last) ? DRAIN : RUN;
            DRAIN:   state_d = (!s1_v_q && !s2_v_q) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ow_q       <= '0;
            fw_q       <= '0;
            st_q       <= '0;
            cfg_err_q  <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_idx1_q  <= '0;
            s1_idx2_q  <= '0;
            s2_v_q     <= 1'b0;
            s2_dr_q    <= '0;
            s2_idx1_q  <= '0;
            pair_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= (state_q == IDLE) && start && !legal;
            if (start_ok) begin
                ow_q       <= cfg_ow;
                fw_q       <= cfg_fw;
                st_q       <= cfg_st;
                pair_cnt_q <= '0;
                drop_cnt_q <= '0;
            end else begin
                if (accept)
                    pair_cnt_q <= pair_cnt_q + CNT_WIDTH'(1);
                if (s1_v_q && !pdu_keep)
                    drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            end
            if (accept) begin
                s1_v_q    <= 1'b1;
                s1_idx1_q <= in_idx1;
                s1_idx2_q <= in_idx2;
            end else if (s1_adv) begin
                s1_v_q <= 1'b0;
            end
            if (s2_free) begin
                s2_v_q <= s1_v_q && pdu_keep;
                if (s1_v_q && pdu_keep) begin
                    s2_dr_q   <= pdu_dr;
                    s2_idx1_q <= s1_idx1_q;
                end
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_dr    = s2_dr_q;
    assign out_idx1  = s2_idx1_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign cfg_err   = cfg_err_q;
    assign pair_cnt  = pair_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_redundancy_dist_scheduler.sv
// tb_redundancy_dist_scheduler: directed self-checking bench for the pair distance scheduler
module tb_redundancy_dist_scheduler;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, in_last, out_valid, out_ready, busy, done, cfg_err;
    logic [7:0]  cfg_ow, cfg_fw, cfg_st, in_idx1, in_idx2, out_idx1;
    logic [6:0]  out_dr;
    logic [15:0] pair_cnt, drop_cnt;
    int          checks = 0, failures = 0, cyc = 0, done_cnt = 0;
    logic [14:0] q[$];
    int          emit_cyc[$];

    redundancy_dist_scheduler dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_ow(cfg_ow), .cfg_fw(cfg_fw), .cfg_st(cfg_st),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx1(in_idx1), .in_idx2(in_idx2), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_dr(out_dr), .out_idx1(out_idx1),
        .busy(busy), .done(done), .cfg_err(cfg_err), .pair_cnt(pair_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q.push_back({out_idx1, out_dr});
            emit_cyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] ow, input logic [7:0] fw, input logic [7:0] st);
        cfg_ow = ow; cfg_fw = fw; cfg_st = st; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] i1, input logic [7:0] i2, input logic last,
                             output int acc, output bit ok);
        in_valid = 1'b1; in_idx1 = i1; in_idx2 = i2; in_last = last;
        ok = 1'b0; acc = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; acc = cyc; end
        end
        tick;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        cfg_ow = '0; cfg_fw = '0; cfg_st = '0; in_idx1 = '0; in_idx2 = '0;
        repeat (3) tick;
        @(negedge clk);
        checks++; if ({in_ready, out_valid, busy, done, cfg_err} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, out_valid, busy, done, cfg_err}); end
        checks++; if (pair_cnt !== 16'd0) begin failures++; $display("FAIL reset_pair_cnt got=%0d exp=0", pair_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if ({out_idx1, out_dr} !== 15'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", {out_idx1, out_dr}); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int acc, b, qb;
        bit ok, got;
        b = done_cnt; qb = q.size();
        out_ready = 1'b1;
        start_run(8'd8, 8'd3, 8'd1);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        tick;
        send_pair(8'd1, 8'd4, 1'b1, acc, ok);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL basic_accept got=timeout exp=accepted"); end
        wait_done(got);
        checks++; if (!got) begin failures++; $display("FAIL basic_done got=timeout exp=pulse"); end
        repeat (3) tick;
        checks++; if (q.size() - qb !== 1) begin failures++; $display("FAIL basic_emit_count got=%0d exp=1", q.size() - qb); end
        checks++; if (q.size() <= qb || q[qb] !== {8'd1, 7'd8}) begin failures++; $display("FAIL basic_dr got=%h exp=%h", (q.size() > qb) ? q[qb] : 15'h7fff, {8'd1, 7'd8}); end
        checks++; if (emit_cyc.size() <= qb || emit_cyc[qb] - acc !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", (emit_cyc.size() > qb) ? emit_cyc[qb] - acc : -1); end
        checks++; if (pair_cnt !== 16'd1 || drop_cnt !== 16'd0) begin failures++; $display("FAIL basic_counts got=%0d/%0d exp=1/0", pair_cnt, drop_cnt); end
        checks++; if (done_cnt - b !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - b); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy); end
    endtask

    task automatic test_stride;
        int acc, b, qb;
        bit ok, got;
        qb = q.size();
        start_run(8'd8, 8'd3, 8'd2);
        send_pair(8'd1, 8'd4, 1'b1, acc, ok);
        in_valid = 1'b0; in_last = 1'b0;
        wait_done(got);
        repeat (2) tick;
        checks++; if (!ok || !got) begin failures++; $display("FAIL stride2_handshake got=%b%b exp=11", ok, got); end
        checks++; if (q.size() - qb !== 1 || q[qb] !== {8'd1, 7'd4}) begin failures++; $display("FAIL stride2_dr got=%h exp=%h", (q.size() > qb) ? q[qb] : 15'h7fff, {8'd1, 7'd4}); end
        b = done_cnt; qb = q.size();
        start_run(8'd8, 8'd3, 8'd3);
        send_pair(8'd1, 8'd4, 1'b1, acc, ok);
        in_valid = 1'b0; in_last = 1'b0;
        wait_done(got);
        repeat (2) tick;
        checks++; if (!ok || !got) begin failures++; $display("FAIL stride3_handshake got=%b%b exp=11", ok, got); end
        checks++; if (q.size() !== qb) begin failures++; $display("FAIL stride3_no_emit got=%0d exp=%0d", q.size(), qb); end
        checks++; if (pair_cnt !== 16'd1 || drop_cnt !== 16'd1) begin failures++; $display("FAIL stride3_counts got=%0d/%0d exp=1/1", pair_cnt, drop_cnt); end
        checks++; if (done_cnt - b !== 1) begin failures++; $display("FAIL stride3_done got=%0d exp=1", done_cnt - b); end
    endtask

    task automatic test_range;
        int acc, qb;
        bit ok, got;
        qb = q.size();
        start_run(8'd40, 8'd3, 8'd1);
        send_pair(8'd0, 8'd60, 1'b1, acc, ok);
        in_valid = 1'b0; in_last = 1'b0;
        wait_done(got);
        repeat (2) tick;
        checks++; if (!ok || !got) begin failures++; $display("FAIL range_handshake got=%b%b exp=11", ok, got); end
        checks++; if (q.size() !== qb || drop_cnt !== 16'd1) begin failures++; $display("FAIL range_800_drop got=%0d/%0d exp=%0d/1", q.size(), drop_cnt, qb); end
        // OW=FW=1 makes n equal d, so 127 fits and 128 does not; (5,2) is reversed
        qb = q.size();
        start_run(8'd1, 8'd1, 8'd1);
        send_pair(8'd0, 8'd127, 1'b0, acc, ok);
        send_pair(8'd0, 8'd128, 1'b0, acc, got);
        ok = ok && got;
        send_pair(8'd5, 8'd2, 1'b1, acc, got);
        in_valid = 1'b0; in_last = 1'b0;
        ok = ok && got;
        wait_done(got);
        repeat (2) tick;
        checks++; if (!ok || !got) begin failures++; $display("FAIL edge_handshake got=%b%b exp=11", ok, got); end
        checks++; if (q.size() - qb !== 1 || q[qb] !== {8'd0, 7'd127}) begin failures++; $display("FAIL edge_dr127 got=%h exp=%h", (q.size() > qb) ? q[qb] : 15'h7fff, {8'd0, 7'd127}); end
        checks++; if (pair_cnt !== 16'd3 || drop_cnt !== 16'd2) begin failures++; $display("FAIL edge_counts got=%0d/%0d exp=3/2", pair_cnt, drop_cnt); end
    endtask

    task automatic test_cfg_err;
        logic [23:0] bad [3];
        bad[0] = {8'd8, 8'd0, 8'd1};
        bad[1] = {8'd8, 8'd3, 8'd0};
        bad[2] = {8'd2, 8'd3, 8'd1};
        for (int i = 0; i < 3; i++) begin
            start_run(bad[i][23:16], bad[i][15:8], bad[i][7:0]);
            @(negedge clk);
            checks++; if ({cfg_err, busy, in_ready} !== 3'b100) begin failures++; $display("FAIL cfg_err_pulse_%0d got=%b exp=100", i, {cfg_err, busy, in_ready}); end
            tick;
            @(negedge clk);
            checks++; if ({cfg_err, busy} !== 2'b00) begin failures++; $display("FAIL cfg_err_clear_%0d got=%b exp=00", i, {cfg_err, busy}); end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [14:0] exp [4];
        int b, qb, okc;
        bit got;
        exp[0] = {8'd0, 7'd1}; exp[1] = {8'd1, 7'd7}; exp[2] = {8'd2, 7'd14}; exp[3] = {8'd3, 7'd1};
        b = done_cnt; qb = q.size(); okc = 0;
        out_ready = 1'b0;
        start_run(8'd8, 8'd3, 8'd1);
        fork
            begin
                int acc;
                bit ok;
                for (int k = 0; k < 4; k++) begin
                    send_pair(exp[k][14:7], exp[k][14:7] + ((k == 0) ? 8'd1 : (k == 1) ? 8'd2 : (k == 2) ? 8'd4 : 8'd1), k == 3, acc, ok);
                    okc += int'(ok);
                end
                in_valid = 1'b0; in_last = 1'b0;
            end
            begin
                logic [14:0] v;
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                v = {out_idx1, out_dr};
                checks++; if (!seen || v !== exp[0]) begin failures++; $display("FAIL b2b_first got=%h exp=%h", v, exp[0]); end
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    checks++; if (out_valid !== 1'b1 || {out_idx1, out_dr} !== v) begin failures++; $display("FAIL b2b_stall_%0d got=%b/%h exp=1/%h", k, out_valid, {out_idx1, out_dr}, v); end
                end
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_full got=%b exp=0", in_ready); end
                tick;
                out_ready = 1'b1;
            end
        join
        wait_done(got);
        repeat (2) tick;
        checks++; if (okc !== 4 || !got) begin failures++; $display("FAIL b2b_handshake got=%0d/%b exp=4/1", okc, got); end
        checks++; if (q.size() - qb !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", q.size() - qb); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (q.size() <= qb + k || q[qb + k] !== exp[k]) begin failures++; $display("FAIL b2b_order_%0d got=%h exp=%h", k, (q.size() > qb + k) ? q[qb + k] : 15'h7fff, exp[k]); end
        end
        checks++; if (pair_cnt !== 16'd4 || drop_cnt !== 16'd0 || done_cnt - b !== 1) begin failures++; $display("FAIL b2b_counts got=%0d/%0d/%0d exp=4/0/1", pair_cnt, drop_cnt, done_cnt - b); end
    endtask

    task automatic test_throughput;
        int acc0, acc, qb;
        bit ok, got, all;
        qb = q.size(); all = 1'b1;
        out_ready = 1'b1;
        start_run(8'd8, 8'd3, 8'd1);
        send_pair(8'd0, 8'd1, 1'b0, acc0, ok); all = all && ok;
        send_pair(8'd1, 8'd3, 1'b0, acc, ok);  all = all && ok;
        send_pair(8'd2, 8'd6, 1'b0, acc, ok);  all = all && ok;
        send_pair(8'd3, 8'd4, 1'b1, acc, ok);  all = all && ok;
        in_valid = 1'b0; in_last = 1'b0;
        wait_done(got);
        repeat (2) tick;
        checks++; if (!all || !got || acc - acc0 !== 3) begin failures++; $display("FAIL tput_accept got=%b%b/%0d exp=11/3", all, got, acc - acc0); end
        checks++; if (emit_cyc.size() - qb !== 4 || emit_cyc[qb + 3] - emit_cyc[qb] !== 3) begin failures++; $display("FAIL tput_emit_span got=%0d exp=3", (emit_cyc.size() - qb == 4) ? emit_cyc[qb + 3] - emit_cyc[qb] : -1); end
    endtask

    task automatic test_reset_mid_run;
        int acc, b;
        bit ok, got;
        b = done_cnt;
        out_ready = 1'b0;
        start_run(8'd8, 8'd3, 8'd1);
        send_pair(8'd0, 8'd1, 1'b0, acc, ok);
        send_pair(8'd1, 8'd3, 1'b0, acc, got);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (!ok || !got || {out_valid, busy, in_ready} !== 3'b110 || pair_cnt !== 16'd2) begin failures++; $display("FAIL midrst_pre got=%b/%0d exp=110/2", {out_valid, busy, in_ready}, pair_cnt); end
        reset = 1'b1;
        tick;
        @(negedge clk);
        checks++; if ({out_valid, busy, in_ready, done} !== 4'b0) begin failures++; $display("FAIL midrst_flags got=%b exp=0000", {out_valid, busy, in_ready, done}); end
        checks++; if (pair_cnt !== 16'd0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", pair_cnt, drop_cnt); end
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick;
        checks++; if (done_cnt !== b || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%0d/%b exp=%0d/0", done_cnt, out_valid, b); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stride;
        test_range;
        test_cfg_err;
        test_back_to_back;
        test_throughput;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
